// File: rtl/corefifo_gray_ptr_sync.sv
// ---------------------------------------------------------------------------
// corefifo_gray_ptr_sync
//   Destination-side synchroniser for Gray-coded FIFO pointers. It supports
//   several independent channels. For each channel the block:
//     - resynchronises the Gray pointer through NUM_STAGES flops,
//     - registers the binary form of the synchronised pointer, and
//     - emits a one-cycle 'changed' pulse whenever that value updates.
//
// Optional feature (macro COREFIFO_GRAYSYNC_ERRCHK_EN):
//   When defined, a sticky per-channel 'err' flag is built. It is set when a
//   synchronised pointer moves by more than one bit in a single step.
//   Checking is suppressed until NUM_STAGES+1 clocks after reset releases,
//   so the first value arriving out of reset is never reported as an error.
//   When undefined, err is tied to 0.
//
// Parameters:
//   NUM_STAGES  flop stages per bit (>= 2)
//   ADDRWIDTH   pointer is ADDRWIDTH+1 bits (address + wrap bit)
//   NUM_CH      channel count; channels are packed LSB-first
//
// Ports:
//   clk        destination clock
//   arst       asynchronous reset, active-high
//   gray_in    [NUM_CH*(ADDRWIDTH+1)] unsynchronised Gray pointers
//   gray_sync  [NUM_CH*(ADDRWIDTH+1)] synchronised Gray pointers
//   bin_sync   [NUM_CH*(ADDRWIDTH+1)] registered binary of gray_sync
//   changed    [NUM_CH] one-cycle pulse when bin_sync updates
//   err        [NUM_CH] sticky illegal-step flag
// ---------------------------------------------------------------------------

// Per-channel synchroniser, Gray-to-binary converter and step detector.
module corefifo_gray_ptr_sync_ch #(
    parameter int NUM_STAGES = 2,
    parameter int W          = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [W-1:0] gray_in,
    output logic [W-1:0] gray_sync,
    output logic [W-1:0] bin_sync,
    output logic [W-1:0] step
);
    logic [NUM_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                 gray_prev;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int s = 1; s < NUM_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign gray_sync = sync_q[NUM_STAGES-1];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            gray_prev <= '0;
            bin_sync  <= '0;
        end else begin
            gray_prev <= gray_sync;
            bin_sync  <= gray2bin(gray_sync);
        end
    end

    // Bits that moved since last cycle. A nonzero value means an update.
    // More than one set bit means an illegal Gray step.
    assign step = gray_sync ^ gray_prev;
endmodule

module corefifo_gray_ptr_sync #(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int NUM_CH     = 1
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] gray_in,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] gray_sync,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] bin_sync,
    output logic [NUM_CH-1:0]               changed,
    output logic [NUM_CH-1:0]               err
);
    localparam int W = ADDRWIDTH + 1;

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("corefifo_gray_ptr_sync: NUM_STAGES must be >= 2");
    end

    logic [NUM_CH-1:0][W-1:0] step;
    logic [NUM_CH-1:0]        upd;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        corefifo_gray_ptr_sync_ch #(
            .NUM_STAGES (NUM_STAGES),
            .W          (W)
        ) u_ch (
            .clk       (clk),
            .arst      (arst),
            .gray_in   (gray_in[c*W +: W]),
            .gray_sync (gray_sync[c*W +: W]),
            .bin_sync  (bin_sync[c*W +: W]),
            .step      (step[c])
        );
        assign upd[c] = |step[c];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) changed <= '0;
        else      changed <= upd;
    end

`ifdef COREFIFO_GRAYSYNC_ERRCHK_EN
    localparam int ARM_CNT = NUM_STAGES + 1;
    localparam int CW      = $clog2(ARM_CNT + 1);

    logic [CW-1:0]     arm_cnt;
    logic              armed;
    logic [NUM_CH-1:0] err_set;

    // armed goes high after ARM_CNT post-reset edges. The edge that first
    // compares a real input value against the cleared prev register
    // (edge NUM_STAGES+1) still sees armed low.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + CW'(1);
            if (arm_cnt == CW'(ARM_CNT - 1)) armed <= 1'b1;
        end
    end

    // x & (x-1) is nonzero exactly when x has two or more set bits.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
        assign err_set[c] = |(step[c] & (step[c] - W'(1)));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) err <= '0;
        else      err <= err | (err_set & {NUM_CH{armed}});
    end
`else
    assign err = '0;
`endif
endmodule

// File: tb/tb_corefifo_gray_ptr_sync.sv
module tb_corefifo_gray_ptr_sync;
    localparam int NS  = 2;
    localparam int AW  = 3;
    localparam int NCH = 2;
    localparam int W   = AW + 1;
    localparam int FW  = NCH * W;

    logic          clk = 1'b0;
    logic          arst;
    logic [FW-1:0] gray_in;
    logic [FW-1:0] gray_sync, bin_sync;
    logic [NCH-1:0] changed, err;

    corefifo_gray_ptr_sync #(.NUM_STAGES(NS), .ADDRWIDTH(AW), .NUM_CH(NCH)) dut (
        .clk(clk), .arst(arst), .gray_in(gray_in), .gray_sync(gray_sync),
        .bin_sync(bin_sync), .changed(changed), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  due;   // cycle after which the changed pulse must be visible
        bit  ill;   // step is multi-bit and checked while armed
    } exp_t;

    exp_t          q0[$], q1[$];
    int            n_chk = 0, n_fail = 0;
    int            cyc = 0, relcnt = 0;
    logic [FW-1:0] hist [0:8191];
    logic [NCH-1:0] errm = '0;
    logic [W-1:0]  last [NCH];
    int            pc [NCH];

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [FW-1:0] g2b_all(input logic [FW-1:0] g);
        logic [FW-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*W +: W] = g2b(g[c*W +: W]);
        return r;
    endfunction

    function automatic int popc(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += v[i];
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected-response generator: each distinct sampled input value on a
    // channel becomes one changed pulse NS edges later.
    initial begin
        for (int c = 0; c < NCH; c++) last[c] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (arst) begin
                relcnt = 0;
                q0.delete(); q1.delete();
                errm = '0;
                hist[cyc] = '0;
                for (int c = 0; c < NCH; c++) last[c] = '0;
            end else begin
                relcnt++;
                hist[cyc] = gray_in;
                for (int c = 0; c < NCH; c++) begin
                    logic [W-1:0] g;
                    exp_t e;
                    g = gray_in[c*W +: W];
                    if (g != last[c]) begin
                        e.due = cyc + NS;
                        e.ill = (relcnt >= 2) && (popc(g ^ last[c]) > 1);
                        if (c == 0) q0.push_back(e); else q1.push_back(e);
                        last[c] = g;
                    end
                end
            end
        end
    end

    // Monitor: compares every output away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (arst) begin
                chk("rst_gray_sync", 32'(gray_sync), 32'h0);
                chk("rst_bin_sync", 32'(bin_sync), 32'h0);
                chk("rst_changed", 32'(changed), 32'h0);
                chk("rst_err", 32'(err), 32'h0);
            end else begin
                chk("gray_sync", 32'(gray_sync), (relcnt >= NS) ? 32'(hist[cyc-NS+1]) : 32'h0);
                chk("bin_sync", 32'(bin_sync), (relcnt >= NS+1) ? 32'(g2b_all(hist[cyc-NS])) : 32'h0);
                for (int c = 0; c < NCH; c++) begin
                    bit   have, expc;
                    exp_t e;
                    have = (c == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (have) e = (c == 0) ? q0[0] : q1[0];
                    expc = have && (e.due <= cyc);
                    chk($sformatf("changed[%0d]", c), 32'(changed[c]), 32'(expc));
                    if (expc) begin
                        chk($sformatf("latency[%0d]", c), 32'(cyc), 32'(e.due));
                        if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
`ifdef COREFIFO_GRAYSYNC_ERRCHK_EN
                        if (e.ill) errm[c] = 1'b1;
`endif
                    end
                end
                chk("err", 32'(err), 32'(errm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int b);
        logic [W-1:0] bb;
        bb = W'(b);
        pc[c] = int'(bb);
        gray_in[c*W +: W] = bb ^ (bb >> 1);
    endtask

    initial begin
        arst = 1'b1;
        gray_in = 8'hFF;
        pc[0] = 0; pc[1] = 0;
        repeat (4) tick();
        // Value held through reset release: one pulse on both channels, no err.
        gray_in = 8'hA5;
        tick();
        arst = 1'b0;
        repeat (8) tick();

        // Restart from zero so later steps start from a legal pointer.
        arst = 1'b1;
        tick();
        gray_in = '0;
        tick();
        arst = 1'b0;
        repeat (6) tick();

        // Single legal step on ch0.
        set_ch(0, 1);
        repeat (5) tick();

        // Full walk with wrap: 2..15 then 0.
        for (int v = 2; v <= 16; v++) begin
            set_ch(0, v % 16);
            repeat ($urandom_range(1, 2)) tick();
        end
        repeat (4) tick();

        // Illegal 2-bit step on ch1: Gray 0001 -> 0010.
        set_ch(1, 1);
        repeat (4) tick();
        gray_in[W +: W] = 4'b0010;
        pc[1] = 3;
        repeat (6) tick();

        // Random legal counting, with an asynchronous reset pulse midway.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                arst = 1'b1;
                #1;
                chk("midrst_gray_sync", 32'(gray_sync), 32'h0);
                chk("midrst_bin_sync", 32'(bin_sync), 32'h0);
                chk("midrst_changed", 32'(changed), 32'h0);
                chk("midrst_err", 32'(err), 32'h0);
                tick();
                tick();
                arst = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(0, 3))
                    2: set_ch(c, pc[c] + 1);
                    3: set_ch(c, pc[c] + W'(4'hF));
                    default: ;
                endcase
            end
            tick();
        end

        repeat (NS + 4) tick();
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
